// File: rtl/paddsb_red_seq_pkg.sv
// Shared types and constants for the serial RED / PADDSB sub-word unit.
package paddsb_red_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       MODE_RED    = 1'b0;
  localparam logic       MODE_PADDSB = 1'b1;
  localparam logic [3:0] SAT_POS     = 4'h7;
  localparam logic [3:0] SAT_NEG     = 4'h8;
  localparam int         NUM_LANES   = 4;
  localparam logic [1:0] LAST_LANE   = 2'(NUM_LANES - 1);

  function automatic logic [9:0] sext_byte(input logic [7:0] b);
    return {{2{b[7]}}, b};
  endfunction

endpackage

// File: rtl/paddsb_red_seq_nibble_sat_addsub.sv
// Combinational signed 4-bit add/subtract that clamps on true two's-complement overflow.
module nibble_sat_addsub
  import paddsb_red_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       sub,
  output logic [3:0] Sum,
  output logic       Ovfl
);

  logic [3:0] b_eff_s;
  logic [3:0] raw_s;

  // Subtraction runs as A + ~B + 1, so one overflow rule covers both operations.
  always_comb begin
    b_eff_s = sub ? ~B : B;
    raw_s   = A + b_eff_s + {3'b000, sub};
    Ovfl    = (A[3] == b_eff_s[3]) && (raw_s[3] != A[3]);
    if (Ovfl) begin
      Sum = A[3] ? SAT_NEG : SAT_POS;
    end else begin
      Sum = raw_s;
    end
  end

endmodule

// File: rtl/paddsb_red_seq.sv
// Multicycle sub-word unit: RED (signed byte reduction) or PADDSB (saturating nibble add/sub), one lane per cycle.
module paddsb_red_seq
  import paddsb_red_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        mode,
  input  logic        sub,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [15:0] Result
);

  state_t      state_r, state_nxt_s;
  logic [15:0] a_r, b_r;
  logic        mode_r, sub_r;
  logic [1:0]  cnt_r;
  logic [9:0]  acc_r;
  logic [15:0] result_r;
  logic        valid_out_r;

  logic [7:0]  byte_s;
  logic [9:0]  acc_sum_s;
  logic [3:0]  a_nib_s, b_nib_s, nib_sum_s;
  logic        nib_ovfl_s;
  logic        last_lane_s;

  // RED lane order walks A low byte, A high byte, B low byte, B high byte.
  always_comb begin
    case (cnt_r)
      2'd0:    byte_s = a_r[7:0];
      2'd1:    byte_s = a_r[15:8];
      2'd2:    byte_s = b_r[7:0];
      2'd3:    byte_s = b_r[15:8];
      default: byte_s = a_r[7:0];
    endcase
  end

  assign acc_sum_s   = acc_r + sext_byte(byte_s);
  assign a_nib_s     = a_r[{cnt_r, 2'b00} +: 4];
  assign b_nib_s     = b_r[{cnt_r, 2'b00} +: 4];
  assign last_lane_s = (cnt_r == LAST_LANE);

  nibble_sat_addsub u_nib (
    .A    (a_nib_s),
    .B    (b_nib_s),
    .sub  (sub_r),
    .Sum  (nib_sum_s),
    .Ovfl (nib_ovfl_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_in) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_lane_s) state_nxt_s = DONE;
        else             state_nxt_s = RUN;
      end
      DONE: begin
        if (ready_in) state_nxt_s = IDLE;
        else          state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ready_out = (state_r == IDLE);
  end

  // Operand capture, lane processing and result/valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
      mode_r      <= MODE_RED;
      sub_r       <= 1'b0;
      cnt_r       <= 2'd0;
      acc_r       <= 10'd0;
      result_r    <= 16'h0000;
      valid_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            a_r      <= A;
            b_r      <= B;
            mode_r   <= mode;
            sub_r    <= sub;
            cnt_r    <= 2'd0;
            acc_r    <= 10'd0;
            result_r <= 16'h0000;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + 2'd1;
          if (mode_r == MODE_PADDSB) begin
            result_r[{cnt_r, 2'b00} +: 4] <= nib_sum_s;
          end else begin
            acc_r <= acc_sum_s;
            if (last_lane_s) result_r <= {{6{acc_sum_s[9]}}, acc_sum_s};
          end
          if (last_lane_s) valid_out_r <= 1'b1;
        end
        DONE: begin
          if (ready_in) valid_out_r <= 1'b0;
        end
        default: begin
          cnt_r       <= 2'd0;
          valid_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out = valid_out_r;
  assign Result    = result_r;

endmodule

// File: tb/tb_paddsb_red_seq.sv
// Scoreboard bench for paddsb_red_seq: driver pushes expected results, a monitor pops on each new valid_out.
module tb_paddsb_red_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic        mode;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        valid_out;
  logic        ready_in;
  logic [15:0] Result;

  typedef struct {
    logic [15:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        prev_v = 1'b0;
  logic [15:0] held = 16'h0000;

  paddsb_red_seq dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mode      (mode),
    .sub       (sub),
    .A         (A),
    .B         (B),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .Result    (Result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new valid_out pops the scoreboard; while held, Result must stay frozen.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (valid_out && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 16'h0001, 16'h0000);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", Result, e.res);
          check("latency", 16'(cyc - e.acc_cyc), 16'd4);
          held = e.res;
        end
      end else if (valid_out) begin
        check("result_held", Result, held);
      end
      prev_v = valid_out;
    end
  end

  task automatic issue(input logic m, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 20 && !ready_out; i++) @(negedge clk);
    check("ready_wait_timeout", {15'd0, ready_out}, 16'h0001);
    valid_in = 1'b1;
    mode     = m;
    sub      = s;
    A        = a;
    B        = b;
    @(negedge clk);
    valid_in = 1'b0;
    e.res     = exp;
    e.acc_cyc = cyc;
    sb.push_back(e);
    check("ready_out_busy", {15'd0, ready_out}, 16'h0000);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !valid_out; i++) @(negedge clk);
    check("valid_wait_timeout", {15'd0, valid_out}, 16'h0001);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (sb.size() != 0 || !ready_out); i++) @(negedge clk);
    check("drain_timeout", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    mode     = 1'b0;
    sub      = 1'b0;
    A        = 16'h0000;
    B        = 16'h0000;
    ready_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready_out", {15'd0, ready_out}, 16'h0001);
    check("rst_valid_out", {15'd0, valid_out}, 16'h0000);
    check("rst_result", Result, 16'h0000);
    rst = 1'b0;

    issue(1'b0, 1'b0, 16'h7F7F, 16'h7F7F, 16'h01FC);
    issue(1'b0, 1'b0, 16'h8080, 16'h8080, 16'hFE00);
    issue(1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0000);
    issue(1'b1, 1'b0, 16'h7835, 16'h18D2, 16'h7807);
    issue(1'b1, 1'b0, 16'h8E11, 16'hFF22, 16'h8D33);
    drain();

    // Backpressure on a PADDSB subtract.
    ready_in = 1'b0;
    issue(1'b1, 1'b1, 16'h7812, 16'h8134, 16'h78EE);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      mode     = 1'b0;
      A        = 16'hFFFF;
      B        = 16'hFFFF;
      @(negedge clk);
      check("bp_ready_out", {15'd0, ready_out}, 16'h0000);
      check("bp_valid_out", {15'd0, valid_out}, 16'h0001);
      check("bp_result", Result, 16'h78EE);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {15'd0, ready_out}, 16'h0001);
    check("bp_release_valid", {15'd0, valid_out}, 16'h0000);
    check("bp_release_result", Result, 16'h78EE);
    drain();

    // Reset in RUN after two lanes are done.
    @(negedge clk);
    valid_in = 1'b1;
    mode     = 1'b1;
    sub      = 1'b0;
    A        = 16'h7835;
    B        = 16'h18D2;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_valid_out", {15'd0, valid_out}, 16'h0000);
    check("abort_result", Result, 16'h0000);
    check("abort_ready_out", {15'd0, ready_out}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 1'b0, 16'h0102, 16'h0304, 16'h000A);
    drain();
    repeat (3) @(negedge clk);
    check("idle_no_spurious", {15'd0, valid_out}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
